fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction fetch unit with prefetch buffer; replaces the fixed PC register, +4 adder and PC mux path of the single-cycle core.
- Issues in-order word requests to an instruction memory over a req/gnt/rvalid interface, with up to DEPTH requests outstanding.
- Buffers returned instructions with their PCs in a FIFO and hands them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush of buffered and in-flight instructions. This is the front end for the multicycle and pipelined core generations.

Parameters:
- XLEN, 32, address/PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; word aligned.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-low reset.
- o_imem_req  out  1  request valid.
- o_imem_addr  out  XLEN  request word address.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  response data valid.
- i_imem_rdata  in  ILEN  response instruction.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  XLEN  new fetch PC.
- o_insn_vld  out  1  FIFO head valid.
- o_insn  out  ILEN  FIFO head instruction.
- o_insn_pc  out  XLEN  FIFO head PC.
- i_insn_rdy  in  1  decode accepts head.
- o_pc_debug  out  XLEN  current fetch PC (f_pc).

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is synchronous, active-low. All state updates on the rising edge of i_clk.
- Reset values:
  - f_pc = RESET_PC and resp_pc = RESET_PC.
  - FIFO empty; os_cnt = 0; drop_cnt = 0.
  - o_imem_req = 0; o_insn_vld = 0.
  - o_insn = 32'h0000_0013 (NOP) whenever the FIFO is empty; o_insn_pc = 0 when empty.
- State:
  - f_pc: next request address.
  - resp_pc: PC of the next non-dropped response.
  - os_cnt (0..DEPTH): all in-flight requests.
  - drop_cnt (0..DEPTH): oldest in-flight requests to discard.
  - FIFO of {pc, insn} with count fcnt.
- Request issue:
  - o_imem_req = 1 iff reset is deasserted, i_redirect = 0, and fcnt + os_cnt < DEPTH. This is combinational from state and i_redirect.
  - o_imem_addr = f_pc.
  - Address is held stable while req is high and gnt is low.
  - On req && gnt: f_pc <= f_pc + 4 (wraps modulo 2^XLEN), os_cnt++.
- Response:
  - Memory returns data in order, at least 1 cycle after grant.
  - i_imem_rvalid with os_cnt == 0 is ignored.
  - Otherwise os_cnt--. Then:
    - If drop_cnt > 0: discard the data, drop_cnt--.
    - Else: push {resp_pc, i_imem_rdata}, resp_pc <= resp_pc + 4.
  - Grant and response in the same cycle: os_cnt unchanged.
- Downstream:
  - o_insn_vld = (fcnt != 0); o_insn and o_insn_pc show the FIFO head.
  - Pop on o_insn_vld && i_insn_rdy.
  - Push and pop in the same cycle are allowed, including when full.
  - The FIFO never overflows, because issue is gated by fcnt + os_cnt.
- Redirect (highest priority):
  - In the i_redirect cycle: no request is issued, and any pop or push is suppressed.
  - FIFO flushed (fcnt <= 0).
  - f_pc <= {i_redirect_pc[XLEN-1:2], 2'b00}; resp_pc <= the same value.
  - drop_cnt <= os_cnt_next. os_cnt_next counts all in-flight requests after this cycle's response, if any; a response arriving in this cycle is itself discarded.
  - o_insn_vld = 0 from the next cycle.
  - Back-to-back redirects: the last one wins.
  - Redirect and reset together: reset wins.
- Reset mid-operation: all counters and the FIFO clear. The memory is reset by the same signal; stray rvalid arriving with os_cnt == 0 is ignored.
- Latency: redirect to first o_imem_req is 1 cycle. With a 1-cycle memory, redirect to o_insn_vld is 3 cycles.

Test Plan:
- Reset, then 1-cycle memory with gnt always 1, i_insn_rdy = 1 → o_imem_addr sequence 0, 4, 8, ...; o_insn_pc follows 0, 4, 8 with matching data; o_insn_vld first high 2 cycles after reset release.
- i_insn_rdy = 0 for 20 cycles, DEPTH = 4 → exactly 4 grants, then o_imem_req = 0; fcnt = 4; on rdy = 1, PCs 0, 4, 8, 12 drain in order, then fetch resumes at 16.
- 3-cycle memory latency with 3 requests in flight, then redirect to 0x100 → the 3 old responses are dropped; first delivered instruction has o_insn_pc = 0x100.
- Redirect to 0x102 → o_imem_addr = 0x100; redirect asserted in the same cycle as a response → that response is discarded, and the FIFO is empty next cycle.
- gnt held low for 5 cycles → o_imem_addr stays constant; reset asserted with requests in flight → o_insn_vld = 0, and after release fetch restarts at RESET_PC with the stray response ignored.
- Fetch near 0xFFFF_FFFC → next address wraps to 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order word requests on a req/gnt/rvalid memory port,
// buffers {pc, insn} pairs in a prefetch FIFO, and flushes everything on a redirect.
module fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     ILEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_reset,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [ILEN-1:0] i_imem_rdata,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_insn_vld,
   output logic [ILEN-1:0] o_insn,
   output logic [XLEN-1:0] o_insn_pc,
   input  logic            i_insn_rdy,
   output logic [XLEN-1:0] o_pc_debug
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

   logic [XLEN-1:0] f_pc_q, f_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   os_cnt_q, os_cnt_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   fcnt_q, fcnt_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0] pc_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_d [DEPTH];
   logic [ILEN-1:0] insn_mem_q [DEPTH];
   logic [ILEN-1:0] insn_mem_d [DEPTH];

   logic            grant;
   logic            resp;
   logic            drop;
   logic            push;
   logic            pop;
   logic [SW-1:0]   occupancy;
   logic [XLEN-1:0] redirect_pc_aligned;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^i_redirect_pc[1:0];
   assign redirect_pc_aligned = {i_redirect_pc[XLEN-1:2], 2'b00};

   // Buffered plus in-flight entries bound issue, so a granted response always has a slot.
   assign occupancy  = SW'(fcnt_q) + SW'(os_cnt_q);
   assign o_imem_req = i_reset && !i_redirect && (occupancy < SW'(DEPTH));
   assign o_imem_addr = f_pc_q;
   assign o_pc_debug  = f_pc_q;

   assign o_insn_vld = (fcnt_q != '0);
   assign o_insn     = o_insn_vld ? insn_mem_q[rd_ptr_q] : NOP;
   assign o_insn_pc  = o_insn_vld ? pc_mem_q[rd_ptr_q] : '0;

   assign grant = o_imem_req && i_imem_gnt;
   assign resp  = i_imem_rvalid && (os_cnt_q != '0);
   assign drop  = resp && (drop_cnt_q != '0);
   assign push  = resp && !drop && !i_redirect;
   assign pop   = o_insn_vld && i_insn_rdy && !i_redirect;

   always_comb begin
      f_pc_d     = f_pc_q;
      resp_pc_d  = resp_pc_q;
      os_cnt_d   = os_cnt_q + CW'(grant) - CW'(resp);
      drop_cnt_d = drop_cnt_q;
      fcnt_d     = fcnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      pc_mem_d   = pc_mem_q;
      insn_mem_d = insn_mem_q;

      if (i_redirect) begin
         // Everything still in flight after this cycle belongs to the old stream.
         f_pc_d     = redirect_pc_aligned;
         resp_pc_d  = redirect_pc_aligned;
         drop_cnt_d = os_cnt_d;
         fcnt_d     = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (grant) begin
            f_pc_d = f_pc_q + XLEN'(4);
         end
         if (drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
         if (push) begin
            pc_mem_d[wr_ptr_q]   = resp_pc_q;
            insn_mem_d[wr_ptr_q] = i_imem_rdata;
            wr_ptr_d             = wr_ptr_q + PW'(1);
            resp_pc_d            = resp_pc_q + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         fcnt_d = fcnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         f_pc_q     <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         os_cnt_q   <= '0;
         drop_cnt_q <= '0;
         fcnt_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         f_pc_q     <= f_pc_d;
         resp_pc_q  <= resp_pc_d;
         os_cnt_q   <= os_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         fcnt_q     <= fcnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
      pc_mem_q   <= pc_mem_d;
      insn_mem_q <= insn_mem_d;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable in-order memory model plus a
// scoreboard of expected {pc, insn} pairs pushed at grant time and popped at delivery.
module tb_fetch_unit;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ILEN     = 32;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gnt = 1'b1;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        rdy = 1'b1;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        insn_vld;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic [31:0] pc_debug;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (XLEN),
      .ILEN     (ILEN),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_gnt    (gnt),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_insn_vld    (insn_vld),
      .o_insn        (insn),
      .o_insn_pc     (insn_pc),
      .i_insn_rdy    (rdy),
      .o_pc_debug    (pc_debug)
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } item_t;

   mreq_t       pend[$];
   item_t       exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned lat = 1;
   int unsigned grants = 0;
   int unsigned pops = 0;
   int unsigned g0;
   logic [31:0] exp_fpc = RESET_PC;
   logic [31:0] last_pop_pc = '0;
   logic [31:0] first_pop_pc = '0;
   logic [31:0] prev_gnt_addr = '0;
   bit          saw_wrap = 1'b0;
   bit          stray = 1'b0;

   logic        s_req, s_vld, s_rv;
   logic [31:0] s_addr, s_insn, s_ipc, s_dbg;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive memory response, sample mid-cycle, update models, advance.
   task automatic cycle();
      item_t e;
      rvalid = 1'b0;
      rdata  = '0;
      s_rv   = 1'b0;
      if (rst_n) begin
         if (stray) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
         end else if (pend.size() != 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_data(pend[0].addr);
            s_rv   = 1'b1;
         end
      end
      #2;
      s_req  = imem_req;
      s_addr = imem_addr;
      s_vld  = insn_vld;
      s_insn = insn;
      s_ipc  = insn_pc;
      s_dbg  = pc_debug;
      if (!rst_n) begin
         exp_q.delete();
         pend.delete();
         exp_fpc = RESET_PC;
      end else begin
         if (s_req && gnt) begin
            chk("imem_addr", s_addr, exp_fpc);
            if (s_addr == 32'h0 && prev_gnt_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            prev_gnt_addr = s_addr;
            pend.push_back('{addr: s_addr, due: cyc + lat});
            exp_q.push_back('{pc: exp_fpc, insn: mem_data(exp_fpc)});
            exp_fpc += 32'd4;
            grants++;
         end
         if (s_vld && rdy && !redirect) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '{pc: 32'hBAD0_BAD0, insn: 32'hBAD1_BAD1};
            chk("insn_pc", s_ipc, e.pc);
            chk("insn", s_insn, e.insn);
            if (pops == 0) first_pop_pc = s_ipc;
            last_pop_pc = s_ipc;
            pops++;
         end
         if (s_rv) void'(pend.pop_front());
         if (redirect) begin
            exp_q.delete();
            exp_fpc = {redirect_pc[31:2], 2'b00};
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      // Reset values.
      cycle();
      chk("reset_req", s_req, 0);
      cycle();
      chk("reset_vld", s_vld, 0);
      chk("reset_insn_nop", s_insn, 32'h0000_0013);
      chk("reset_insn_pc", s_ipc, 0);
      chk("reset_pc_debug", s_dbg, RESET_PC);

      // Streaming with 1-cycle memory.
      rst_n = 1'b1;
      cycle();
      chk("first_req", s_req, 1);
      chk("vld_c0", s_vld, 0);
      cycle();
      chk("vld_c1", s_vld, 0);
      cycle();
      chk("vld_c2", s_vld, 1);
      chk("first_pc", s_ipc, 0);
      for (int i = 0; i < 10; i++) cycle();

      // Backpressure fills FIFO, then drains in order.
      rst_n = 1'b0;
      cycle();
      cycle();
      rdy   = 1'b0;
      rst_n = 1'b1;
      g0    = grants;
      for (int i = 0; i < 20; i++) cycle();
      chk("stall_grants", grants - g0, 4);
      chk("stall_req", s_req, 0);
      chk("stall_vld", s_vld, 1);
      rdy  = 1'b1;
      pops = 0;
      cycle();
      chk("drain_pc0", first_pop_pc, 0);
      chk("drain_full_req", s_req, 0);
      cycle();
      chk("resume_req", s_req, 1);
      chk("resume_addr", s_addr, 16);
      cycle();
      cycle();
      chk("drain_pc12", last_pop_pc, 12);
      for (int i = 0; i < 6; i++) cycle();

      // 3-cycle memory, three in flight, then redirect.
      lat         = 3;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      cycle();
      redirect = 1'b0;
      for (int n = 0; n < 10 && pend.size() < 3; n++) cycle();
      chk("three_inflight", pend.size(), 3);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      pops        = 0;
      cycle();
      redirect = 1'b0;
      for (int i = 0; i < 12; i++) cycle();
      chk("redirect_has_pops", pops != 0, 1);
      chk("redirect_first_pc", first_pop_pc, 32'h100);

      // Misaligned redirect coinciding with a response.
      lat = 1;
      for (int i = 0; i < 6; i++) cycle();
      for (int n = 0; n < 10 && !(pend.size() != 0 && pend[0].due <= cyc); n++) cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      cycle();
      chk("redirect_with_resp", s_rv, 1);
      redirect = 1'b0;
      cycle();
      chk("flush_vld", s_vld, 0);
      chk("aligned_req", s_req, 1);
      chk("aligned_addr", s_addr, 32'h100);

      // Grant withheld: address must hold.
      gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("hold_req", s_req, 1);
         chk("hold_addr", s_addr, exp_fpc);
      end
      gnt = 1'b1;
      lat = 3;
      cycle();
      cycle();

      // Reset with requests in flight, stray response after release.
      rst_n = 1'b0;
      cycle();
      chk("midreset_req", s_req, 0);
      cycle();
      chk("midreset_vld", s_vld, 0);
      rst_n = 1'b1;
      stray = 1'b1;
      pops  = 0;
      cycle();
      stray = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      chk("restart_has_pops", pops != 0, 1);
      chk("restart_first_pc", first_pop_pc, RESET_PC);

      // Address wrap.
      lat         = 1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      cycle();
      redirect = 1'b0;
      saw_wrap = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      chk("addr_wrap", saw_wrap, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
